// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master arbiter and related shared-bus controllers.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_NACK    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } rsp_err_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping around.
module rr_arbiter #(
  parameter int unsigned N    = 2,
  parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    pick_o
);

  logic [PtrW-1:0] idx;

  always_comb begin
    pick_o = '0;
    idx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PtrW'((32'(ptr_i) + i) % N);
      if (req_i[idx] && (pick_o == '0)) begin
        pick_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin sharing of one byte-level I2C master engine, one full transaction per grant.
// Define I2C_ARB_WATCHDOG_EN to add the transaction watchdog that aborts a hung engine.
module i2c_master_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TO_W    = 20,
  parameter int unsigned TO_CYC  = 500000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*I2C_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_rw,
  input  logic [NUM_REQ*LEN_W-1:0]      req_len,
  output logic [NUM_REQ-1:0]            rsp_done,
  output logic [1:0]                    rsp_err,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          m_cmd_valid,
  input  logic                          m_cmd_ready,
  output logic [I2C_ADDR_W-1:0]         m_cmd_addr,
  output logic                          m_cmd_rw,
  output logic [LEN_W-1:0]              m_cmd_len,
  input  logic                          m_done,
  input  logic                          m_nack,
  output logic                          m_abort,
  output logic                          busy
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t             state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [PtrW-1:0]        idx_q, idx_d;
  logic [PtrW-1:0]        ptr_q, ptr_d;
  logic [I2C_ADDR_W-1:0]  addr_q, addr_d;
  logic                   rw_q, rw_d;
  logic [LEN_W-1:0]       len_q, len_d;
  rsp_err_t               err_q, err_d;

  logic [NUM_REQ-1:0]     pick;
  logic [PtrW-1:0]        pick_idx;
  logic [I2C_ADDR_W-1:0]  sel_addr;
  logic                   sel_rw;
  logic [LEN_W-1:0]       sel_len;
  logic                   wd_expire;
  logic                   timeout_hit;

  rr_arbiter #(
    .N    (NUM_REQ),
    .PtrW (PtrW)
  ) u_rr_arbiter (
    .req_i  (req_valid),
    .ptr_i  (ptr_q),
    .pick_o (pick)
  );

  // Winner index and its command fields, muxed from the flat request buses.
  always_comb begin
    pick_idx = '0;
    sel_addr = '0;
    sel_rw   = 1'b0;
    sel_len  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        pick_idx = PtrW'(i);
        sel_addr = req_addr[i*I2C_ADDR_W +: I2C_ADDR_W];
        sel_rw   = req_rw[i];
        sel_len  = req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    len_d       = len_q;
    err_d       = err_q;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d = pick;
          idx_d   = pick_idx;
          addr_d  = sel_addr;
          rw_d    = sel_rw;
          len_d   = sel_len;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // m_done here is an engine protocol violation and is deliberately not looked at.
        if (wd_expire) begin
          state_d     = DONE;
          err_d       = ERR_TIMEOUT;
          timeout_hit = 1'b1;
        end else if (m_cmd_ready) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A real completion beats a simultaneous watchdog expiry.
        if (m_done) begin
          state_d = DONE;
          err_d   = m_nack ? ERR_NACK : ERR_OK;
        end else if (wd_expire) begin
          state_d     = DONE;
          err_d       = ERR_TIMEOUT;
          timeout_hit = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = (idx_q == PtrW'(NUM_REQ - 1)) ? '0 : idx_q + PtrW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      len_q   <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

`ifdef I2C_ARB_WATCHDOG_EN
  logic [TO_W-1:0] wd_q, wd_d;
  logic            abort_q, abort_d;

  assign wd_expire = (state_q inside {ISSUE, BUSY}) && (wd_q == TO_W'(TO_CYC - 1));

  always_comb begin
    wd_d    = '0;
    abort_d = timeout_hit;
    if (state_q inside {ISSUE, BUSY}) begin
      wd_d = wd_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q    <= '0;
      abort_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      abort_q <= abort_d;
    end
  end

  assign m_abort = abort_q;
`else
  logic unused_wd_cfg;

  assign wd_expire     = 1'b0;
  assign m_abort       = 1'b0;
  assign unused_wd_cfg = ^{TO_W'(TO_CYC), timeout_hit};
`endif

  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign m_cmd_valid = (state_q == ISSUE);
  assign m_cmd_addr  = addr_q;
  assign m_cmd_rw    = rw_q;
  assign m_cmd_len   = len_q;
  assign req_ready   = ((state_q == ISSUE) && m_cmd_ready) ? grant_q : '0;
  assign rsp_done    = (state_q == DONE) ? grant_q : '0;
  assign rsp_err     = (state_q == DONE) ? err_q : ERR_OK;

endmodule
